// File: rtl/pdu_crc_framer_pkg.sv
// Shared BLE link-layer types: framer state encoding, CRC-24 polynomial and
// the single-bit CRC-24 update used by both the TX framer and the RX checker.
package ble_types;

  typedef enum logic [2:0] {
    FramerIdle,
    FramerHdr,
    FramerPayload,
    FramerCrc,
    FramerDone
  } ble_framer_state_t;

  localparam logic [23:0] BLE_CRC24_POLY = 24'h00065B;

  function automatic logic [23:0] ble_crc24_step(input logic [23:0] crc,
                                                 input logic        din,
                                                 input logic [23:0] poly = BLE_CRC24_POLY);
    logic fb;
    fb = crc[23] ^ din;
    return {crc[22:0], 1'b0} ^ (fb ? poly : 24'h000000);
  endfunction

endpackage

// File: rtl/pdu_crc_framer_crc24.sv
// Serial CRC-24 register: preset loads a seed, enable advances one bit.
// Shared between the TX framer and the RX CRC checker.
module ble_crc24_serial
  import ble_types::*;
#(
  parameter logic [23:0] POLY = BLE_CRC24_POLY
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        preset,
  input  logic [23:0] preset_val,
  input  logic        enable,
  input  logic        bit_in,
  output logic [23:0] crc
);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      crc <= 24'h000000;
    end else if (preset) begin
      crc <= preset_val;
    end else if (enable) begin
      crc <= ble_crc24_step(crc, bit_in, POLY);
    end
  end

endmodule

// File: rtl/pdu_crc_framer.sv
// BLE PDU framer: serialises header, prefetched payload words and an optional
// CRC-24 as a gapless 1-bit AXI-Stream towards the whitener.
module pdu_crc_framer
  import ble_types::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [23:0] CRC_POLY   = BLE_CRC24_POLY,
  parameter int          LEN_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  hdr_ext,
  input  logic                  crc_enable,
  input  logic [23:0]           crc_init,
  input  logic [23:0]           packet_hdr,
  input  logic [DATA_WIDTH-1:0] payload_tdata,
  input  logic                  payload_tvalid,
  output logic                  payload_tready,
  output logic                  output_tdata,
  output logic                  output_tvalid,
  input  logic                  output_tready,
  output logic                  output_tlast,
  output logic                  busy,
  output logic                  event_crc,
  output logic                  done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHW   = $clog2(DATA_WIDTH) + 1;
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int PW    = LEN_WIDTH + 3;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  ble_framer_state_t     state;
  logic                  hdr_ext_q;
  logic                  crc_en_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [23:0]           hdr_q;
  logic [4:0]            bit_cnt;
  logic [LEN_WIDTH-1:0]  fetch_left;
  logic [PW-1:0]         pay_left;
  logic [DATA_WIDTH-1:0] shreg;
  logic [SHW-1:0]        sh_cnt;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [BW-1:0]         buf_bytes;
  logic                  buf_vld;
  logic                  evt_crc_q;
  logic [23:0]           crc_q;

  logic                  in_frame, hdr_last, hs, start_ok, acc, load_sh, sh_shift;
  logic [LEN_WIDTH-1:0]  take;

  assign in_frame = (state == FramerHdr) || (state == FramerPayload);
  assign hdr_last = (bit_cnt == (hdr_ext_q ? 5'd23 : 5'd15));
  assign hs       = output_tvalid && output_tready;
  assign start_ok = start && !abort && ((state == FramerIdle) || (state == FramerDone));
  assign acc      = payload_tvalid && payload_tready;
  assign take     = (fetch_left >= BYTES_L) ? BYTES_L : fetch_left;
  assign sh_shift = hs && (state == FramerPayload);
  // Reload on the last bit's handshake keeps the stream gapless; an empty
  // shift register (underrun or header phase) loads as soon as a word exists.
  assign load_sh  = buf_vld && in_frame &&
                    ((sh_cnt == '0) || ((sh_cnt == SHW'(1)) && sh_shift));

  assign payload_tready = !buf_vld && (fetch_left != '0) && in_frame;
  assign busy           = in_frame || (state == FramerCrc);
  assign event_crc      = evt_crc_q;
  assign done           = hs && output_tlast;

  always_comb begin
    output_tvalid = 1'b0;
    output_tdata  = 1'b0;
    output_tlast  = 1'b0;
    case (state)
      FramerHdr: begin
        output_tvalid = 1'b1;
        output_tdata  = hdr_q[bit_cnt];
        output_tlast  = hdr_last && (len_q == '0) && !crc_en_q;
      end
      FramerPayload: begin
        output_tvalid = (sh_cnt != '0);
        output_tdata  = output_tvalid && shreg[0];
        output_tlast  = output_tvalid && (pay_left == PW'(1)) && !crc_en_q;
      end
      FramerCrc: begin
        output_tvalid = 1'b1;
        output_tdata  = crc_q[5'd23 - bit_cnt];
        output_tlast  = (bit_cnt == 5'd23);
      end
      default: ;
    endcase
  end

  ble_crc24_serial #(.POLY(CRC_POLY)) u_crc (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .preset     (start_ok),
    .preset_val (crc_init),
    .enable     (hs && in_frame && !abort),
    .bit_in     (output_tdata),
    .crc        (crc_q)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= FramerIdle;
      hdr_ext_q  <= 1'b0;
      crc_en_q   <= 1'b0;
      len_q      <= '0;
      bit_cnt    <= '0;
      fetch_left <= '0;
      pay_left   <= '0;
      sh_cnt     <= '0;
      buf_bytes  <= '0;
      buf_vld    <= 1'b0;
      evt_crc_q  <= 1'b0;
    end else begin
      evt_crc_q <= 1'b0;
      if (abort) begin
        state      <= FramerIdle;
        fetch_left <= '0;
        pay_left   <= '0;
        sh_cnt     <= '0;
        buf_vld    <= 1'b0;
      end else if (start_ok) begin
        state      <= FramerHdr;
        hdr_ext_q  <= hdr_ext;
        crc_en_q   <= crc_enable;
        len_q      <= packet_hdr[8 +: LEN_WIDTH];
        bit_cnt    <= '0;
        fetch_left <= packet_hdr[8 +: LEN_WIDTH];
        pay_left   <= {packet_hdr[8 +: LEN_WIDTH], 3'b000};
        sh_cnt     <= '0;
        buf_vld    <= 1'b0;
      end else begin
        case (state)
          FramerHdr: if (hs) begin
            if (hdr_last) begin
              bit_cnt <= '0;
              if (len_q != '0) begin
                state <= FramerPayload;
              end else if (crc_en_q) begin
                state     <= FramerCrc;
                evt_crc_q <= 1'b1;
              end else begin
                state <= FramerDone;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          FramerPayload: if (hs) begin
            pay_left <= pay_left - PW'(1);
            if (pay_left == PW'(1)) begin
              if (crc_en_q) begin
                state     <= FramerCrc;
                evt_crc_q <= 1'b1;
              end else begin
                state <= FramerDone;
              end
            end
          end
          FramerCrc: if (hs) begin
            if (bit_cnt == 5'd23) state <= FramerDone;
            else                  bit_cnt <= bit_cnt + 5'd1;
          end
          default: ;
        endcase

        if (load_sh) begin
          sh_cnt  <= SHW'({buf_bytes, 3'b000});
          buf_vld <= 1'b0;
        end else if (sh_shift) begin
          sh_cnt <= sh_cnt - SHW'(1);
        end

        if (acc) begin
          buf_bytes  <= BW'(take);
          buf_vld    <= 1'b1;
          fetch_left <= fetch_left - take;
        end
      end
    end
  end

  // Datapath registers: no reset, qualified by the control state above.
  always_ff @(posedge aclk) begin
    if (start_ok) hdr_q <= packet_hdr;
    if (acc)      buf_data <= payload_tdata;
    if (!abort && !start_ok) begin
      if (load_sh)       shreg <= buf_data;
      else if (sh_shift) shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_pdu_crc_framer.sv
// Directed self-checking bench for pdu_crc_framer with an independent bit-level
// reference of the header/payload/CRC-24 stream.
module tb_pdu_crc_framer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, hdr_ext = 1'b0, crc_enable = 1'b0;
  logic [23:0] crc_init = '0, packet_hdr = '0;
  logic [31:0] payload_tdata = '0;
  logic        payload_tvalid = 1'b0, payload_tready;
  logic        output_tdata, output_tvalid, output_tlast;
  logic        output_tready = 1'b0;
  logic        busy, event_crc, done;

  int checks = 0;
  int errors = 0;

  pdu_crc_framer #(.DATA_WIDTH(32), .CRC_POLY(24'h00065B), .LEN_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .hdr_ext(hdr_ext), .crc_enable(crc_enable), .crc_init(crc_init),
    .packet_hdr(packet_hdr), .payload_tdata(payload_tdata),
    .payload_tvalid(payload_tvalid), .payload_tready(payload_tready),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid),
    .output_tready(output_tready), .output_tlast(output_tlast),
    .busy(busy), .event_crc(event_crc), .done(done)
  );

  always #5 aclk = ~aclk;

  logic [31:0] words[$];
  bit          got[$];
  bit          exp_q[$];
  int tlast_idx, tlast_cnt, done_cnt, evt_cnt, evt_at, bubbles, acc_cnt, unstable;
  int timed_out;
  logic first_valid, first_busy, busy_after;

  function automatic logic [23:0] ref_crc(input logic [23:0] c, input logic b);
    logic [23:0] n;
    n = {c[22:0], 1'b0};
    if (c[23] ^ b) n = n ^ 24'h00065B;
    return n;
  endfunction

  task automatic build_exp(input logic hx, input logic [23:0] hdr, input logic ce,
                           input logic [23:0] ci);
    logic [23:0] c;
    logic [31:0] w;
    int len, nh;
    c = ci;
    len = int'(hdr[15:8]);
    nh = hx ? 24 : 16;
    exp_q.delete();
    for (int i = 0; i < nh; i++) begin
      exp_q.push_back(hdr[i]);
      c = ref_crc(c, hdr[i]);
    end
    for (int b = 0; b < len; b++) begin
      w = words[b / 4];
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(w[8 * (b % 4) + i]);
        c = ref_crc(c, w[8 * (b % 4) + i]);
      end
    end
    if (ce) for (int i = 23; i >= 0; i--) exp_q.push_back(c[i]);
  endtask

  // Starts one PDU and collects the stream; stops on done or after abort_after bits.
  task automatic run_frame(input logic hx, input logic [23:0] hdr, input logic ce,
                           input logic [23:0] ci, input int thr, input int abort_after,
                           input bit hold_start);
    int widx, cyc;
    bit fin, prev_stall;
    logic prev_d, prev_l;
    widx = 0; cyc = 0; fin = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
    got.delete();
    tlast_idx = -1; tlast_cnt = 0; done_cnt = 0; evt_cnt = 0; evt_at = -1;
    bubbles = 0; acc_cnt = 0; unstable = 0; timed_out = 0;
    start = 1; hdr_ext = hx; packet_hdr = hdr; crc_enable = ce; crc_init = ci;
    @(posedge aclk); #1;
    if (!hold_start) start = 0;
    hdr_ext = ~hx; packet_hdr = ~hdr; crc_enable = ~ce; crc_init = ~ci;
    while (!fin && cyc < 20000) begin
      output_tready  = (thr == 0) ? 1'b1 : ($urandom_range(99) >= thr);
      payload_tvalid = (widx < words.size()) && ((thr == 0) || ($urandom_range(99) >= thr));
      payload_tdata  = (widx < words.size()) ? words[widx] : 32'hDEADBEEF;
      #1;
      if (cyc == 0) begin first_valid = output_tvalid; first_busy = busy; end
      if (prev_stall && (!output_tvalid || output_tdata !== prev_d || output_tlast !== prev_l))
        unstable++;
      if (!output_tvalid && got.size() > 0 && tlast_cnt == 0) bubbles++;
      if (event_crc) begin evt_cnt++; evt_at = got.size(); end
      if (done) begin done_cnt++; fin = 1; end
      if (payload_tvalid && payload_tready) begin widx++; acc_cnt++; end
      if (output_tvalid && output_tready) begin
        got.push_back(output_tdata);
        if (output_tlast) begin tlast_cnt++; tlast_idx = got.size(); end
      end
      if (abort_after >= 0 && got.size() == abort_after) fin = 1;
      prev_stall = output_tvalid && !output_tready;
      prev_d = output_tdata; prev_l = output_tlast;
      @(posedge aclk); #1;
      cyc++;
    end
    if (!fin) timed_out = 1;
    busy_after = busy;
    start = 0; payload_tvalid = 0; output_tready = 1;
  endtask

  task automatic check_stream(input string name, input int nbits);
    int bad, first;
    bad = 0; first = -1;
    checks++;
    if (timed_out != 0) begin
      errors++; $display("FAIL %s_timeout: no done within cycle budget", name);
    end
    checks++;
    if (got.size() != nbits) begin
      errors++; $display("FAIL %s_bitcount: got %0d bits, want %0d", name, got.size(), nbits);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] != exp_q[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0 || exp_q.size() != nbits) begin
      errors++;
      $display("FAIL %s_stream: %0d wrong bits, first at %0d (model %0d bits)", name, bad, first, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({output_tvalid, output_tdata, output_tlast, payload_tready, busy, event_crc, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {output_tvalid, output_tdata, output_tlast, payload_tready, busy, event_crc, done});
    end
    aresetn = 1;
    @(posedge aclk); #1;
  endtask

  task automatic test_empty_crc();
    words.delete();
    build_exp(1'b0, 24'h000000, 1'b1, 24'h555555);
    run_frame(1'b0, 24'h000000, 1'b1, 24'h555555, 0, -1, 0);
    check_stream("empty", 40);
    checks++;
    if (first_valid !== 1'b1 || first_busy !== 1'b1) begin
      errors++; $display("FAIL empty_latency: tvalid=%b busy=%b want 1 1", first_valid, first_busy);
    end
    checks++;
    if (tlast_idx != 40 || tlast_cnt != 1) begin
      errors++; $display("FAIL empty_tlast: at %0d count %0d want 40 1", tlast_idx, tlast_cnt);
    end
    checks++;
    if (evt_cnt != 1 || evt_at != 16 || done_cnt != 1) begin
      errors++; $display("FAIL empty_pulses: evt=%0d@%0d done=%0d want 1@16 1", evt_cnt, evt_at, done_cnt);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++; $display("FAIL empty_busy_fall: got %b want 0", busy_after);
    end
  endtask

  task automatic test_payload_gapless();
    words = '{32'h04030201, 32'h000000AA};
    build_exp(1'b0, 24'h000502, 1'b1, 24'h123456);
    run_frame(1'b0, 24'h000502, 1'b1, 24'h123456, 0, -1, 0);
    check_stream("len5", 80);
    checks++;
    if (acc_cnt != 2 || bubbles != 0) begin
      errors++; $display("FAIL len5_flow: words=%0d bubbles=%0d want 2 0", acc_cnt, bubbles);
    end
    checks++;
    if (got.size() < 57 || got[16] != 1 || got[17] != 0 || got[24] != 0 || got[25] != 1 ||
        got[49] != 1 || got[55] != 1) begin
      errors++; $display("FAIL len5_bytes: payload bits not 01 02 .. AA LSB-first");
    end
    checks++;
    if (tlast_idx != 80 || evt_at != 56) begin
      errors++; $display("FAIL len5_markers: tlast@%0d evt@%0d want 80 56", tlast_idx, evt_at);
    end
  endtask

  task automatic test_no_crc_ext_hdr();
    words = '{32'h00C0FFEE};
    build_exp(1'b1, 24'hA5036C, 1'b0, 24'h000000);
    run_frame(1'b1, 24'hA5036C, 1'b0, 24'h000000, 0, -1, 0);
    check_stream("nocrc", 48);
    checks++;
    if (tlast_idx != 48 || evt_cnt != 0 || done_cnt != 1) begin
      errors++; $display("FAIL nocrc_markers: tlast@%0d evt=%0d done=%0d want 48 0 1", tlast_idx, evt_cnt, done_cnt);
    end
    checks++;
    if (got.size() < 48 || got[0] != 0 || got[16] != 1 || got[23] != 1 || got[24] != 0 || got[47] != 1) begin
      errors++; $display("FAIL nocrc_bits: header/payload bit positions wrong");
    end
  endtask

  task automatic test_throttle_max_len();
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    build_exp(1'b0, 24'h00FF1E, 1'b1, 24'hABCDEF);
    run_frame(1'b0, 24'h00FF1E, 1'b1, 24'hABCDEF, 30, -1, 0);
    check_stream("len255", 2080);
    checks++;
    if (unstable != 0 || acc_cnt != 64) begin
      errors++; $display("FAIL len255_flow: unstable=%0d words=%0d want 0 64", unstable, acc_cnt);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    words = '{32'h11223344, 32'h55667788};
    run_frame(1'b0, 24'h000811, 1'b1, 24'h555555, 0, 26, 0);
    abort = 1;
    seen_done = 0;
    @(posedge aclk); #1;
    abort = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done++;
      checks++;
      if ({output_tvalid, busy, payload_tready} !== 3'b000 || seen_done != 0) begin
        errors++;
        $display("FAIL abort_idle: cycle %0d tvalid/busy/ready=%b done=%0d want 000 0", i,
                 {output_tvalid, busy, payload_tready}, seen_done);
      end
      @(posedge aclk); #1;
    end
    words = '{32'hCAFE0102};
    build_exp(1'b0, 24'h000240, 1'b1, 24'h0F0F0F);
    run_frame(1'b0, 24'h000240, 1'b1, 24'h0F0F0F, 0, -1, 0);
    check_stream("after_abort", 56);
  endtask

  task automatic test_start_priority();
    words = '{32'h000000F0};
    build_exp(1'b0, 24'h000133, 1'b1, 24'h777777);
    run_frame(1'b0, 24'h000133, 1'b1, 24'h777777, 0, -1, 1);
    check_stream("hold_start", 48);
    checks++;
    if (done_cnt != 1 || tlast_cnt != 1) begin
      errors++; $display("FAIL hold_start_pulses: done=%0d tlast=%0d want 1 1", done_cnt, tlast_cnt);
    end
    start = 1; abort = 1; packet_hdr = 24'h000000; crc_enable = 1;
    @(posedge aclk); #1;
    start = 0; abort = 0;
    checks++;
    if ({output_tvalid, busy} !== 2'b00) begin
      errors++; $display("FAIL start_abort_done: tvalid/busy=%b want 00", {output_tvalid, busy});
    end
    words = '{32'h12345678};
    run_frame(1'b0, 24'h000400, 1'b1, 24'h000001, 0, 20, 0);
    start = 1; abort = 1;
    @(posedge aclk); #1;
    start = 0; abort = 0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({output_tvalid, busy, payload_tready} !== 3'b000) begin
      errors++; $display("FAIL start_abort_mid: tvalid/busy/ready=%b want 000", {output_tvalid, busy, payload_tready});
    end
  endtask

  task automatic test_mid_reset();
    words = '{32'h0A0B0C0D};
    run_frame(1'b0, 24'h000400, 1'b1, 24'h000000, 0, 8, 0);
    aresetn = 0;
    @(posedge aclk); #1;
    checks++;
    if ({output_tvalid, busy, payload_tready, event_crc} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: tvalid/busy/ready/evt=%b want 0000",
                         {output_tvalid, busy, payload_tready, event_crc});
    end
    aresetn = 1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_crc();
    test_payload_gapless();
    test_no_crc_ext_hdr();
    test_throttle_max_len();
    test_abort();
    test_start_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdu_crc_framer.md
Name: pdu_crc_framer

Overview:
Parametrised successor to the TX PDU/CRC generator. It frames one BLE link-layer PDU as a serial bit stream: a 16- or 24-bit header, then 0..255 payload bytes fetched as DATA_WIDTH-bit words, then an optional CRC-24. Serialisation is gapless because the block prefetches payload words. It sits between the payload FIFO and the whitener/modulator path of the TX baseband.

Parameters:
DATA_WIDTH, 32, payload word width in bits; multiple of 8, range 8..64; byte 0 is in bits [7:0].
CRC_POLY, 24'h00065B, CRC-24 feedback taps (BLE: x^24+x^10+x^9+x^6+x^4+x^3+x+1).
LEN_WIDTH, 8, width of the payload length field, taken from packet_hdr[8 +: LEN_WIDTH].

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
start  in  1  begin a PDU; sampled in IDLE/DONE only
abort  in  1  cancel the current PDU immediately
hdr_ext  in  1  1 = 24-bit header (CTEInfo present), 0 = 16-bit
crc_enable  in  1  1 = append CRC-24; 0 = test mode, no CRC
crc_init  in  24  CRC preset
packet_hdr  in  24  PDU header, bit 0 sent first
payload_tdata  in  DATA_WIDTH  payload word
payload_tvalid  in  1  AXIS valid
payload_tready  out  1  AXIS ready
output_tdata  out  1  serial bit
output_tvalid  out  1  AXIS valid
output_tready  in  1  AXIS ready
output_tlast  out  1  marks the final bit of the PDU
busy  out  1  high from the cycle after start until done
event_crc  out  1  one-cycle pulse when the first CRC bit is presented
done  out  1  one-cycle pulse on the final bit handshake

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register = 0, prefetch buffer empty.
- On start, latch hdr_ext, crc_enable, crc_init, packet_hdr and len = packet_hdr[15:8]. Other input changes mid-PDU are ignored.
- States:
  - IDLE: on start go to HDR.
  - HDR: shift 16 or 24 header bits. Go to PAYLOAD if len > 0. Otherwise go to CRC, or to DONE when crc_enable = 0.
  - PAYLOAD: shift len*8 bits. Then go to CRC, or to DONE when crc_enable = 0.
  - CRC: shift 24 bits, then go to DONE.
  - DONE: on start go to HDR.
- Latency: output_tvalid rises in the cycle after start. The first bit is packet_hdr[0].
- Bit order:
  - Header and payload bytes are sent LSB first, byte 0 first.
  - CRC register bit 23 is sent first, bit 0 last.
- CRC update:
  - The CRC register advances once per output handshake during HDR and PAYLOAD.
  - feedback = crc[23] ^ bit; crc <= {crc[22:0], 1'b0} ^ (feedback ? CRC_POLY : 0).
  - The register is frozen during the CRC state and shifted out.
- Payload fetch:
  - One-word prefetch buffer. payload_tready = buffer empty AND words still to fetch.
  - The bytes remaining counter decrements by min(DATA_WIDTH/8, remaining) per accepted word.
  - Prefetch may start during HDR.
  - On the handshake of the last bit of a word, the shift register reloads from the buffer in the same cycle. Output then has no bubble when the source kept up.
  - If the buffer is empty, output_tvalid drops until a word arrives. Bits already shifted are unaffected.
  - Unused high bytes of the final word are discarded and never transmitted or CRC'd.
- Handshake: output_tdata and output_tlast hold stable while output_tvalid is high and output_tready is low.
- output_tlast:
  - Asserted with the last CRC bit.
  - When crc_enable = 0: asserted with the last payload bit, or with the last header bit if len = 0.
- Pulses:
  - event_crc pulses in the first cycle of the CRC state.
  - done pulses in the cycle of the tlast handshake.
  - busy falls in the cycle after done.
- Abort:
  - Highest priority. Next cycle state = IDLE; output_tvalid, payload_tready and busy = 0; buffer flushed; no done pulse.
  - Abort and start in the same cycle: abort wins.
- start while busy is ignored.
- aresetn low mid-PDU gives the reset state in the next cycle.
- Bits emitted: hdr bits (16 or 24) + 8*len + (crc_enable ? 24 : 0), exactly.

Decomposition:
- ble_types package:
  - enum ble_framer_state_t {FramerIdle, FramerHdr, FramerPayload, FramerCrc, FramerDone}
  - constant BLE_CRC24_POLY
  - function automatic ble_crc24_step(crc, bit)
- Sub-module ble_crc24_serial: preset, enable, bit in, crc out. It is reused by the RX checker.

Test Plan:
1. hdr_ext=0, packet_hdr=24'h000000 (len 0), crc_init=24'h555555, crc_enable=1 -> 40 bits, tlast on bit 40, CRC bits match the ble_crc24_step model; event_crc and done each pulse exactly once.
2. len=5, DATA_WIDTH=32, payload 0x04030201, 0x000000AA, tready always 1 -> 2 words accepted, 16+40+24 = 80 bits, no bubbles, high bytes of word 2 never sent.
3. hdr_ext=1, len=3, crc_enable=0 -> 24+24 = 48 bits, tlast on the last payload bit, no event_crc.
4. Random output_tready and payload_tvalid throttling, len=255 -> 16+2040+24 bits; data stable while stalled; stream matches the golden model.
5. abort at payload bit 10 -> next cycle tvalid=0, busy=0, no done; a following start with new crc_init gives a correct full PDU.
6. start held high during busy, and start+abort in the same cycle -> no restart mid-PDU, abort wins, block ends in IDLE.
